// File: rtl/fdtd_pkg.sv
// Shared types and the sum-narrowing helper for the streaming FDTD update engine.
// Build option FDTD_SAT_EN: narrowing clamps to the signed DW range instead of wrapping.
package fdtd_pkg;

    localparam int FDTD_DW   = 32;
    localparam int FDTD_FRAC = 16;
    localparam int FDTD_CNT  = 10;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fdtd_state_e;
    typedef enum logic {MODE_HY, MODE_EZ} fdtd_mode_e;

    function automatic logic signed [FDTD_DW-1:0] fdtd_narrow(input logic signed [FDTD_DW+1:0] s);
`ifdef FDTD_SAT_EN
        logic signed [FDTD_DW+1:0] max_v;
        logic signed [FDTD_DW+1:0] min_v;
        max_v = (FDTD_DW+2)'({1'b0, {(FDTD_DW-1){1'b1}}});
        min_v = -max_v - (FDTD_DW+2)'(1);
        if (s > max_v) begin
            return {1'b0, {(FDTD_DW-1){1'b1}}};
        end else if (s < min_v) begin
            return {1'b1, {(FDTD_DW-1){1'b0}}};
        end else begin
            return FDTD_DW'(s);
        end
`else
        return FDTD_DW'(s);
`endif
    endfunction

endpackage

// File: rtl/fdtd_mac.sv
// One registered multiply/shift lane: term = (coef * val) >>> FRAC, kept in DW+2 bits.
module fdtd_mac
    import fdtd_pkg::*;
#(
    parameter int DW   = FDTD_DW,
    parameter int FRAC = FDTD_FRAC
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic signed [DW-1:0] coef_i,
    input  logic signed [DW:0]   val_i,
    output logic signed [DW+1:0] term_o
);

    logic signed [2*DW:0] prod;

    assign prod = (2*DW+1)'(coef_i) * (2*DW+1)'(val_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            term_o <= '0;
        end else if (en_i) begin
            term_o <= (DW+2)'(prod >>> FRAC);
        end
    end

endmodule

// File: rtl/fdtd_stream_upd.sv
// Streaming 1D FDTD Hy/Ez sweep engine: valid/ready in and out, 2-stage MAC pipeline.
// Build option FDTD_SAT_EN selects saturating (vs wrapping) narrowing of the final sum.
module fdtd_stream_upd
    import fdtd_pkg::*;
#(
    parameter int DATA_WIDTH = FDTD_DW,
    parameter int FRAC_BITS  = FDTD_FRAC,
    parameter int CNT_WIDTH  = FDTD_CNT
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         start_i,
    input  logic                         mode_i,
    input  logic [CNT_WIDTH-1:0]         num_cells_i,
    input  logic [CNT_WIDTH-1:0]         src_idx_i,
    input  logic                         src_en_i,
    input  logic signed [DATA_WIDTH-1:0] c_self_i,
    input  logic signed [DATA_WIDTH-1:0] c_curl_i,
    input  logic signed [DATA_WIDTH-1:0] cezj_i,
    input  logic signed [DATA_WIDTH-1:0] jz_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DATA_WIDTH-1:0] self_old_i,
    input  logic signed [DATA_WIDTH-1:0] other_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_WIDTH-1:0]        field_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
);

    localparam int DW = DATA_WIDTH;
    localparam logic signed [DW-1:0] ONE = DW'(1) << FRAC_BITS;

    fdtd_state_e state_q, state_d;
    fdtd_mode_e  mode_q;

    logic [CNT_WIDTH-1:0] n_q, src_idx_q, in_cnt_q, out_cnt_q;
    logic signed [DW-1:0] jz_q, nb_q, prev_self_q;
    logic                 err_q, tail_q, v1_q, out_valid_q;
    logic [DW-1:0]        field_q;

    logic advance, in_fire, out_fire, start_ok, start_bad, last_in, last_out;
    logic issue, tail_fire, pass, inject;
    logic signed [DW-1:0] self_op, self_coef, src_coef;
    logic signed [DW:0]   diff, curl_b;
    logic signed [DW+1:0] self_t, curl_t, src_t, sum;

    assign advance   = !out_valid_q || out_ready_i;
    assign in_fire   = in_valid_i && advance && (state_q == RUN);
    assign out_fire  = out_valid_q && out_ready_i;
    assign start_ok  = start_i && (state_q == IDLE) && (num_cells_i >= CNT_WIDTH'(2));
    assign start_bad = start_i && (state_q == IDLE) && (num_cells_i < CNT_WIDTH'(2));
    assign last_in   = (in_cnt_q == n_q - CNT_WIDTH'(1));
    assign last_out  = (out_cnt_q == n_q - CNT_WIDTH'(1));

    // Hy emits cell k-1 on beat k plus a pass-through tail in DRAIN; Ez emits cell k on beat k.
    always_comb begin
        issue     = 1'b0;
        tail_fire = 1'b0;
        pass      = 1'b0;
        inject    = 1'b0;
        self_op   = self_old_i;
        diff      = (DW+1)'(other_i) - (DW+1)'(nb_q);
        if (in_fire) begin
            if (mode_q == MODE_HY) begin
                issue   = (in_cnt_q != '0);
                self_op = prev_self_q;
            end else begin
                issue  = 1'b1;
                pass   = (in_cnt_q == '0);
                inject = src_en_i && (src_idx_q == in_cnt_q) && (src_idx_q != '0);
            end
        end else if ((state_q == DRAIN) && (mode_q == MODE_HY) && !tail_q && advance) begin
            issue     = 1'b1;
            tail_fire = 1'b1;
            pass      = 1'b1;
            self_op   = prev_self_q;
        end
    end

    // Boundary cells ride the same lanes as an exact multiply by 1.0 with no curl term.
    assign self_coef = pass ? ONE : c_self_i;
    assign curl_b    = pass ? '0 : diff;
    assign src_coef  = inject ? cezj_i : '0;

    fdtd_mac #(.DW(DW), .FRAC(FRAC_BITS)) u_mac_self (
        .clk_i(CLK), .rst_i(RST), .en_i(advance),
        .coef_i(self_coef), .val_i((DW+1)'(self_op)), .term_o(self_t)
    );

    fdtd_mac #(.DW(DW), .FRAC(FRAC_BITS)) u_mac_curl (
        .clk_i(CLK), .rst_i(RST), .en_i(advance),
        .coef_i(c_curl_i), .val_i(curl_b), .term_o(curl_t)
    );

    fdtd_mac #(.DW(DW), .FRAC(FRAC_BITS)) u_mac_src (
        .clk_i(CLK), .rst_i(RST), .en_i(advance),
        .coef_i(src_coef), .val_i((DW+1)'(jz_q)), .term_o(src_t)
    );

    assign sum = self_t + curl_t + src_t;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
                     else if (start_bad) state_d = DONE;
            RUN:     if (in_fire && last_in) state_d = DRAIN;
            DRAIN:   if (out_fire && last_out) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            mode_q      <= MODE_HY;
            n_q         <= '0;
            src_idx_q   <= '0;
            jz_q        <= '0;
            err_q       <= 1'b0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            tail_q      <= 1'b0;
            nb_q        <= '0;
            prev_self_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                mode_q      <= fdtd_mode_e'(mode_i);
                n_q         <= num_cells_i;
                src_idx_q   <= src_idx_i;
                jz_q        <= jz_i;
                err_q       <= 1'b0;
                in_cnt_q    <= '0;
                out_cnt_q   <= '0;
                tail_q      <= 1'b0;
                nb_q        <= '0;
                prev_self_q <= '0;
            end else if (start_bad) begin
                err_q <= 1'b1;
            end
            if (in_fire) begin
                in_cnt_q    <= in_cnt_q + CNT_WIDTH'(1);
                nb_q        <= other_i;
                prev_self_q <= self_old_i;
            end
            if (out_fire) begin
                out_cnt_q <= out_cnt_q + CNT_WIDTH'(1);
            end
            if (tail_fire) begin
                tail_q <= 1'b1;
            end
        end
    end

    // Both pipeline stages stall together so a presented beat stays put under backpressure.
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            field_q     <= '0;
        end else if (advance) begin
            v1_q        <= issue;
            out_valid_q <= v1_q;
            if (v1_q) begin
                field_q <= fdtd_narrow(sum);
            end
        end
    end

    assign in_ready_o  = advance && (state_q == RUN);
    assign out_valid_o = out_valid_q;
    assign field_o     = field_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;

endmodule
